// File: rtl/sobel_pkg.sv
// Shared types, kernel coefficients and saturation helpers for the streaming Sobel engine.
package sobel_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StFlush = 2'd2;
    localparam state_t StDone  = 2'd3;

    // Indexed [row][col], row 0 = top, col 0 = left.
    localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    function automatic int unsigned calc_num_out(input int unsigned w, input int unsigned h);
        return (w - 2) * (h - 2);
    endfunction

    function automatic int unsigned calc_acc_width(input int unsigned pix_width);
        return pix_width + 3;
    endfunction

    // min(|g|, 2^ow - 1); ow must be below 32.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] g, input int unsigned ow);
        logic [31:0] mag;
        logic [31:0] top;
        mag = (g < 0) ? 32'(-g) : 32'(g);
        top = (32'd1 << ow) - 32'd1;
        return (mag > top) ? top : mag;
    endfunction

    // Clip to [-2^(ow-1), 2^(ow-1)-1], two's complement.
    function automatic logic [31:0] sat_signed(input logic signed [31:0] g,
                                               input int unsigned ow);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (g > hi) return hi;
        if (g < lo) return lo;
        return g;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line buffer plus 3x3 window; the exported window already includes the incoming pixel.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned img_w = 128,
    parameter int unsigned img_h = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [width-1:0] pixel,
    output logic [width-1:0] win [3][3],
    output logic             win_valid
);

    localparam int unsigned col_bits = $clog2(img_w);
    localparam int unsigned row_bits = $clog2(img_h);

    logic [width-1:0]    line0 [img_w];
    logic [width-1:0]    line1 [img_w];
    logic [width-1:0]    col_l [3];
    logic [width-1:0]    col_m [3];
    logic [width-1:0]    new_col [3];
    logic [col_bits-1:0] col_q;
    logic [row_bits-1:0] row_q;

    always_comb begin
        new_col[0] = line0[col_q];
        new_col[1] = line1[col_q];
        new_col[2] = pixel;
        for (int r = 0; r < 3; r++) begin
            win[r][0] = col_l[r];
            win[r][1] = col_m[r];
            win[r][2] = new_col[r];
        end
        win_valid = valid && (row_q >= row_bits'(2)) && (col_q >= col_bits'(2));
    end

    // Line contents need no reset: every slot is rewritten before a valid window uses it.
    always_ff @(posedge clk) begin
        if (valid) begin
            line0[col_q] <= line1[col_q];
            line1[col_q] <= pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            for (int r = 0; r < 3; r++) begin
                col_l[r] <= '0;
                col_m[r] <= '0;
            end
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end else if (valid) begin
            for (int r = 0; r < 3; r++) begin
                col_l[r] <= col_m[r];
                col_m[r] <= new_col[r];
            end
            if (col_q == col_bits'(img_w - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel engine: raster-order read of A, one GX/GY result per valid window.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned width        = 8,
    parameter int unsigned out_width    = 8,
    parameter int unsigned img_w        = 128,
    parameter int unsigned img_h        = 128,
    parameter int unsigned A_depth_bits = 14,
    parameter int unsigned G_depth_bits = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Start,
    input  logic                    abs_mode,
    output logic                    Busy,
    output logic                    Done,
    output logic                    A_read_en,
    output logic [A_depth_bits-1:0] A_read_address,
    input  logic [width-1:0]        A_read_data_out,
    output logic                    GX_write_en,
    output logic [G_depth_bits-1:0] GX_write_address,
    output logic [out_width-1:0]    GX_write_data_in,
    output logic                    GY_write_en,
    output logic [G_depth_bits-1:0] GY_write_address,
    output logic [out_width-1:0]    GY_write_data_in
);

    localparam int unsigned acc_width = calc_acc_width(width);
    localparam int unsigned num_pix   = img_w * img_h;

    state_t                  state_q, state_d;
    logic                    abs_q, abs_d;
    logic                    rd_en_d, busy_d, done_d, clear;
    logic [A_depth_bits-1:0] rd_addr_d;
    logic                    rd_valid_q;
    logic                    wr_en_d, wr_en_q;
    logic [G_depth_bits-1:0] wr_cnt_q, wr_addr_q;
    logic [out_width-1:0]    gx_out, gy_out, gx_q, gy_q;
    logic [width-1:0]        win [3][3];
    logic                    win_valid;
    logic signed [acc_width-1:0] gx, gy, term;

    sobel_line_buffer #(
        .width(width),
        .img_w(img_w),
        .img_h(img_h)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .valid    (rd_valid_q),
        .pixel    (A_read_data_out),
        .win      (win),
        .win_valid(win_valid)
    );

    always_comb begin
        state_d   = state_q;
        abs_d     = abs_q;
        rd_en_d   = A_read_en;
        rd_addr_d = A_read_address;
        busy_d    = Busy;
        done_d    = Done;
        clear     = 1'b0;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d   = StRun;
                    abs_d     = abs_mode;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    clear     = 1'b1;
                end
            end
            StRun, StFlush: begin
                if (!Start) begin
                    state_d = StIdle;
                    rd_en_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (state_q == StRun) begin
                    if (A_read_address == A_depth_bits'(num_pix - 1)) begin
                        rd_en_d = 1'b0;
                        state_d = StFlush;
                    end else begin
                        rd_addr_d = A_read_address + 1'b1;
                    end
                end else if (!rd_valid_q) begin
                    // Last pixel already consumed; its write lands this cycle.
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                if (!Start) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gx   = '0;
        gy   = '0;
        term = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                term = signed'({3'b000, win[r][c]});
                gx   = gx + acc_width'(KX[r][c]) * term;
                gy   = gy + acc_width'(KY[r][c]) * term;
            end
        end
        gx_out  = out_width'(abs_q ? sat_abs(32'(gx), out_width) : sat_signed(32'(gx), out_width));
        gy_out  = out_width'(abs_q ? sat_abs(32'(gy), out_width) : sat_signed(32'(gy), out_width));
        wr_en_d = win_valid && Start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            abs_q          <= 1'b0;
            A_read_en      <= 1'b0;
            A_read_address <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            rd_valid_q     <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_cnt_q       <= '0;
            wr_addr_q      <= '0;
            gx_q           <= '0;
            gy_q           <= '0;
        end else begin
            state_q        <= state_d;
            abs_q          <= abs_d;
            A_read_en      <= rd_en_d;
            A_read_address <= rd_addr_d;
            Busy           <= busy_d;
            Done           <= done_d;
            rd_valid_q     <= A_read_en && Start;
            wr_en_q        <= wr_en_d;
            if (clear) begin
                wr_cnt_q <= '0;
            end else if (wr_en_d) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (wr_en_d) begin
                wr_addr_q <= wr_cnt_q;
                gx_q      <= gx_out;
                gy_q      <= gy_out;
            end
        end
    end

    assign GX_write_en      = wr_en_q;
    assign GY_write_en      = wr_en_q;
    assign GX_write_address = wr_addr_q;
    assign GY_write_address = wr_addr_q;
    assign GX_write_data_in = gx_q;
    assign GY_write_data_in = gy_q;

endmodule
